// File: rtl/stage5_writeback.sv
// stage5_writeback: final pipeline stage.
// Selects ALU or load result, aligns/extends load data, drives the register
// file write port and counts retired instructions. A one-entry hold buffer
// keeps the SRAM load word alive across a halt stall, since the SRAM return
// is valid for only one cycle.
//
// Optional feature macro: WB_MISALIGN_CHECK_EN
//   defined   -> misaligned LH/LHU/LW do not write rd and pulse misaligned_load
//   undefined -> no misaligned_load port; misaligned loads write the shifted word
//
// Hold FSM states:
//   state | meaning
//   PASS  | load word taken straight from mem_read_data
//   HELD  | load word captured during halt, replayed from hold_data on accept

module stage5_writeback #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axis_memory_to_writeback_tvalid,
  output logic                 axis_memory_to_writeback_tready,
  input  logic [XLEN-1:0]      axis_memory_to_writeback_alu_result,
  input  logic [XLEN-1:0]      axis_memory_to_writeback_branch_target,
  input  logic [31:0]          axis_memory_to_writeback_decoded_instruction,
  input  logic [XLEN-1:0]      mem_read_data,
  input  logic                 halt,
  output logic                 rf_write_enable,
  output logic [4:0]           rf_write_addr,
  output logic [XLEN-1:0]      rf_write_data,
  output logic                 retire_valid,
  output logic [INSTRET_W-1:0] instret
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic                 misaligned_load
`endif
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {PASS = 1'b0, HELD = 1'b1} hold_state_t;

  hold_state_t     state;
  logic [XLEN-1:0] hold_data;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [1:0]      off;
  logic            accept;
  logic            is_load;
  logic            writes_rd;
  logic            misaligned;
  logic [XLEN-1:0] ldw;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] result;

  // branch_target and the upper instruction bits are not needed at writeback
  logic unused_bits;
  assign unused_bits = ^{axis_memory_to_writeback_branch_target,
                         axis_memory_to_writeback_decoded_instruction[31:15]};

  assign opcode  = axis_memory_to_writeback_decoded_instruction[6:0];
  assign rd      = axis_memory_to_writeback_decoded_instruction[11:7];
  assign funct3  = axis_memory_to_writeback_decoded_instruction[14:12];
  assign off     = axis_memory_to_writeback_alu_result[1:0];

  assign axis_memory_to_writeback_tready = !halt;
  assign accept  = axis_memory_to_writeback_tvalid && !halt;
  assign is_load = (opcode == OP_LOAD);

  assign ldw = (state == HELD) ? hold_data : mem_read_data;
  assign sh  = ldw >> {off, 3'b000};

`ifdef WB_MISALIGN_CHECK_EN
  assign misaligned = is_load &&
                      ((((funct3 == F3_LH) || (funct3 == F3_LHU)) && off[0]) ||
                       ((funct3 == F3_LW) && (off != 2'd0)));
`else
  assign misaligned = 1'b0;
`endif

  // Decode which opcodes produce an rd value
  always_comb begin
    writes_rd = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP, OP_LOAD: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

  // Align and extend the load word; LW uses the shifted word so a misaligned
  // LW (when unchecked) writes the upper bytes shifted down, zero-filled
  always_comb begin
    load_data = ldw;
    case (funct3)
      F3_LB:  load_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_LBU: load_data = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LH:  load_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LHU: load_data = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_LW:  load_data = sh;
      default: load_data = ldw;
    endcase
  end

  // Result select: loads carry the effective address in alu_result
  always_comb begin
    result = axis_memory_to_writeback_alu_result;
    if (is_load) result = load_data;
  end

  // Hold FSM plus registered write port, retire pulse and instret
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= PASS;
      hold_data       <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= 5'd0;
      rf_write_data   <= '0;
      retire_valid    <= 1'b0;
      instret         <= '0;
`ifdef WB_MISALIGN_CHECK_EN
      misaligned_load <= 1'b0;
`endif
    end else begin
      retire_valid    <= accept;
      rf_write_enable <= accept && writes_rd && (rd != 5'd0) && !misaligned;
`ifdef WB_MISALIGN_CHECK_EN
      misaligned_load <= accept && misaligned;
`endif
      if (accept) begin
        rf_write_addr <= rd;
        rf_write_data <= result;
        instret       <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
      case (state)
        PASS: begin
          if (axis_memory_to_writeback_tvalid && halt && is_load) begin
            hold_data <= mem_read_data;
            state     <= HELD;
          end
        end
        HELD: begin
          if (accept) state <= PASS;
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_stage5_writeback.sv
// Directed testbench for stage5_writeback (default build; misaligned checks
// follow WB_MISALIGN_CHECK_EN if defined for the bench as well).

module tb_stage5_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic        tready;
  logic [31:0] alu_result;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] mem_read_data;
  logic        halt;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        retire_valid;
  logic [63:0] instret;
`ifdef WB_MISALIGN_CHECK_EN
  logic        misaligned_load;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage5_writeback dut (
    .clk                                         (clk),
    .rst                                         (rst),
    .axis_memory_to_writeback_tvalid             (tvalid),
    .axis_memory_to_writeback_tready             (tready),
    .axis_memory_to_writeback_alu_result         (alu_result),
    .axis_memory_to_writeback_branch_target      (branch_target),
    .axis_memory_to_writeback_decoded_instruction(instr),
    .mem_read_data                               (mem_read_data),
    .halt                                        (halt),
    .rf_write_enable                             (rf_write_enable),
    .rf_write_addr                               (rf_write_addr),
    .rf_write_data                               (rf_write_data),
    .retire_valid                                (retire_valid),
    .instret                                     (instret)
`ifdef WB_MISALIGN_CHECK_EN
    ,
    .misaligned_load                             (misaligned_load)
`endif
  );

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, advance one clock, sample 1ns after the edge
  task automatic step(input logic v, input logic h, input logic [31:0] ins,
                      input logic [31:0] alu, input logic [31:0] mrd);
    tvalid        = v;
    halt          = h;
    instr         = ins;
    alu_result    = alu;
    mem_read_data = mrd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic [63:0] cnt);
    chk({tag, "_we"}, {63'd0, rf_write_enable}, {63'd0, we});
    if (we) begin
      chk({tag, "_addr"}, {59'd0, rf_write_addr}, {59'd0, addr});
      chk({tag, "_data"}, {32'd0, rf_write_data}, {32'd0, data});
    end
    chk({tag, "_retire"}, {63'd0, retire_valid}, 64'd1);
    chk({tag, "_instret"}, instret, cnt);
  endtask

  initial begin
    branch_target = 32'h0000_4000;
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("rst_we", {63'd0, rf_write_enable}, 64'd0);
    chk("rst_addr", {59'd0, rf_write_addr}, 64'd0);
    chk("rst_data", {32'd0, rf_write_data}, 64'd0);
    chk("rst_retire", {63'd0, retire_valid}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_tready", {63'd0, tready}, 64'd1);
    rst = 1'b0;

    // ADDI rd=5
    step(1'b1, 1'b0, mk(OP_IMM, 5'd5, 3'b000), 32'h0000_1234, 32'h0);
    chk_wr("addi", 1'b1, 5'd5, 32'h0000_1234, 64'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("idle_we", {63'd0, rf_write_enable}, 64'd0);
    chk("idle_retire", {63'd0, retire_valid}, 64'd0);

    // Byte/half loads, back-to-back
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd3, 3'b000), 32'h0000_1002, 32'h0080_0000);
    chk_wr("lb", 1'b1, 5'd3, 32'hFFFF_FF80, 64'd2);
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd3, 3'b100), 32'h0000_1002, 32'h0080_0000);
    chk_wr("lbu", 1'b1, 5'd3, 32'h0000_0080, 64'd3);
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd7, 3'b001), 32'h0000_2002, 32'h8001_0000);
    chk_wr("lh", 1'b1, 5'd7, 32'hFFFF_8001, 64'd4);
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd7, 3'b101), 32'h0000_2002, 32'h8001_0000);
    chk_wr("lhu", 1'b1, 5'd7, 32'h0000_8001, 64'd5);

    // LW held across a 3-cycle halt; SRAM data is garbage after the first cycle
    step(1'b1, 1'b1, mk(OP_LOAD, 5'd9, 3'b010), 32'h0000_0100, 32'hDEAD_BEEF);
    chk("hold1_tready", {63'd0, tready}, 64'd0);
    chk("hold1_retire", {63'd0, retire_valid}, 64'd0);
    step(1'b1, 1'b1, mk(OP_LOAD, 5'd9, 3'b010), 32'h0000_0100, 32'h1234_5678);
    chk("hold2_we", {63'd0, rf_write_enable}, 64'd0);
    step(1'b1, 1'b1, mk(OP_LOAD, 5'd9, 3'b010), 32'h0000_0100, 32'h5555_AAAA);
    chk("hold3_instret", instret, 64'd5);
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd9, 3'b010), 32'h0000_0100, 32'hBAD0_BAD0);
    chk_wr("held_lw", 1'b1, 5'd9, 32'hDEAD_BEEF, 64'd6);

    // rd=0, store, branch: retire without writing
    step(1'b1, 1'b0, mk(OP_IMM, 5'd0, 3'b000), 32'h0000_0055, 32'h0);
    chk_wr("rd0", 1'b0, 5'd0, 32'h0, 64'd7);
    step(1'b1, 1'b0, mk(OP_STORE, 5'd4, 3'b010), 32'h0000_0300, 32'h0);
    chk_wr("store", 1'b0, 5'd0, 32'h0, 64'd8);
    step(1'b1, 1'b0, mk(OP_BRANCH, 5'd6, 3'b000), 32'h0000_0001, 32'h0);
    chk_wr("branch", 1'b0, 5'd0, 32'h0, 64'd9);

    // Misaligned LW (off=1)
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd10, 3'b010), 32'h0000_0401, 32'hAABB_CCDD);
`ifdef WB_MISALIGN_CHECK_EN
    chk_wr("mis_lw", 1'b0, 5'd0, 32'h0, 64'd10);
    chk("mis_pulse", {63'd0, misaligned_load}, 64'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("mis_pulse_end", {63'd0, misaligned_load}, 64'd0);
`else
    chk_wr("mis_lw", 1'b1, 5'd10, 32'h00AA_BBCC, 64'd10);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
`endif

    // Reset in the middle of a held load discards the hold buffer
    step(1'b1, 1'b1, mk(OP_LOAD, 5'd2, 3'b010), 32'h0000_0200, 32'hCAFE_F00D);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    rst = 1'b0;
    chk("rst2_instret", instret, 64'd0);
    chk("rst2_retire", {63'd0, retire_valid}, 64'd0);
    chk("rst2_data", {32'd0, rf_write_data}, 64'd0);

    // Four back-to-back accepts after reset
    step(1'b1, 1'b0, mk(OP_LOAD, 5'd2, 3'b010), 32'h0000_0200, 32'h1122_3344);
    chk_wr("b2b1", 1'b1, 5'd2, 32'h1122_3344, 64'd1);
    step(1'b1, 1'b0, mk(OP_IMM, 5'd1, 3'b000), 32'h0000_0011, 32'h0);
    chk_wr("b2b2", 1'b1, 5'd1, 32'h0000_0011, 64'd2);
    step(1'b1, 1'b0, mk(OP_IMM, 5'd3, 3'b000), 32'h0000_0022, 32'h0);
    chk_wr("b2b3", 1'b1, 5'd3, 32'h0000_0022, 64'd3);
    step(1'b1, 1'b0, mk(OP_IMM, 5'd4, 3'b000), 32'h0000_0033, 32'h0);
    chk_wr("b2b4", 1'b1, 5'd4, 32'h0000_0033, 64'd4);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("end_retire", {63'd0, retire_valid}, 64'd0);
    chk("end_instret", instret, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
